// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32 datapath: sequences fetch, decode,
// execute, memory and writeback over a shared memory port and a shared ALU.
module multicycle_controller #(
    parameter int RESET_STALL_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] ALU_op_o,
    output logic       retire_o,
    output logic       illegal_o
);

    localparam logic [3:0] S_START   = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEM_ADR = 4'd3;
    localparam logic [3:0] S_MEM_RD  = 4'd4;
    localparam logic [3:0] S_MEM_WB  = 4'd5;
    localparam logic [3:0] S_MEM_WR  = 4'd6;
    localparam logic [3:0] S_EXEC_R  = 4'd7;
    localparam logic [3:0] S_EXEC_I  = 4'd8;
    localparam logic [3:0] S_ALU_WB  = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JAL     = 4'd11;
    localparam logic [3:0] S_TRAP    = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] STALL_LAST = 4'(RESET_STALL_CYCLES - 1);

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    // Moore control word for a state; unlisted fields stay 0.
    function automatic ctrl_t moore_decode(input logic [3:0] st);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEM_ADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.adr_src  = 1'b1;
            end
            S_MEM_WB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.retire    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       fetch_done_s;
    logic       store_done_s;

    // Next-state and reset-stall counter logic; unknown state codes park in TRAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_START: begin
                if (cnt_q == STALL_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                if (opcode_i == OP_STORE) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL:    state_d = S_ALU_WB;
            S_TRAP:                       state_d = S_TRAP;
            default:                      state_d = S_TRAP;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_comb begin
        ctrl_d = moore_decode(state_d);
    end

    // State, stall counter and registered control word; reset clears all outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_START;
            cnt_q   <= 4'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Handshake-dependent qualifiers for the Mealy outputs.
    always_comb begin
        fetch_done_s = (state_q == S_FETCH) && mem_ready_i;
        store_done_s = (state_q == S_MEM_WR) && mem_ready_i;
    end

    assign mem_req_o    = ctrl_q.mem_req;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign adr_src_o    = ctrl_q.adr_src;
    assign reg_write_o  = ctrl_q.reg_write;
    assign result_src_o = ctrl_q.result_src;
    assign alu_src_a_o  = ctrl_q.alu_src_a;
    assign alu_src_b_o  = ctrl_q.alu_src_b;
    assign ALU_op_o     = ctrl_q.alu_op;
    assign illegal_o    = ctrl_q.illegal;
    assign ir_write_o   = fetch_done_s;
    assign pc_write_o   = fetch_done_s
                        | ((state_q == S_BRANCH) && zero_i)
                        | (state_q == S_JAL);
    assign retire_o     = ctrl_q.retire | store_done_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a vector table covering every
// instruction class plus hand-written reset-out-of-TRAP and reset-during-store sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       retire, illegal;
    logic [16:0] ctl_s;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_retire = 0;

    multicycle_controller #(.RESET_STALL_CYCLES(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .adr_src_o(adr_src), .ir_write_o(ir_write),
        .pc_write_o(pc_write), .reg_write_o(reg_write), .result_src_o(result_src),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .ALU_op_o(alu_op),
        .retire_o(retire), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, ALU_op, retire, illegal}
    assign ctl_s = {mem_req, mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, retire, illegal};

    localparam logic [16:0] E_ZERO       = 17'd0;
    localparam logic [16:0] E_FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_FETCH_GO   = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MEM_ADR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MEM_RD     = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_WR_WAIT    = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_WR_GO      = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_EXEC_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
    localparam logic [16:0] E_EXEC_I     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0,1'b0};
    localparam logic [16:0] E_ALU_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [16:0] E_BR_T       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b00,2'b01,1'b1,1'b0};
    localparam logic [16:0] E_BR_NT      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b1,1'b0};
    localparam logic [16:0] E_JAL        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0};
    localparam logic [16:0] E_TRAP       = 17'd1;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [16:0] exp_q[$];

    task automatic add(input logic [6:0] op, input logic z, input logic rdy, input logic [16:0] exp);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Pops the oldest expected control word and compares it with the DUT outputs.
    task automatic compare(input string nm);
        logic [16:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (ctl_s !== e) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, ctl_s, e);
        end
        if (retire === 1'b1) n_retire++;
    endtask

    task automatic step(input logic [6:0] op, input logic z, input logic rdy,
                        input logic [16:0] exp, input string nm);
        @(negedge clk);
        opcode = op; zero = z; mem_ready = rdy;
        exp_q.push_back(exp);
        #1;
        compare(nm);
    endtask

    task automatic check_now(input logic [16:0] exp, input string nm);
        exp_q.push_back(exp);
        #1;
        compare(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;

        // R-type (ready also high in non-request states, must be ignored), I-type with a fetch wait.
        add(OP_R,   1'b0, 1'b1, E_FETCH_GO);
        add(OP_R,   1'b0, 1'b1, E_DECODE);
        add(OP_R,   1'b1, 1'b1, E_EXEC_R);
        add(OP_R,   1'b0, 1'b1, E_ALU_WB);
        add(OP_I,   1'b1, 1'b0, E_FETCH_WAIT);
        add(OP_I,   1'b1, 1'b1, E_FETCH_GO);
        add(OP_I,   1'b0, 1'b0, E_DECODE);
        add(OP_I,   1'b0, 1'b0, E_EXEC_I);
        add(OP_I,   1'b0, 1'b0, E_ALU_WB);
        // lw with two wait states in MEM_RD: 7 cycles.
        add(OP_LW,  1'b0, 1'b1, E_FETCH_GO);
        add(OP_LW,  1'b0, 1'b1, E_DECODE);
        add(OP_LW,  1'b0, 1'b1, E_MEM_ADR);
        add(OP_LW,  1'b0, 1'b0, E_MEM_RD);
        add(OP_LW,  1'b0, 1'b0, E_MEM_RD);
        add(OP_LW,  1'b0, 1'b1, E_MEM_RD);
        add(OP_LW,  1'b0, 1'b0, E_MEM_WB);
        // beq taken, then not taken.
        add(OP_BEQ, 1'b0, 1'b1, E_FETCH_GO);
        add(OP_BEQ, 1'b1, 1'b0, E_DECODE);
        add(OP_BEQ, 1'b1, 1'b0, E_BR_T);
        add(OP_BEQ, 1'b0, 1'b1, E_FETCH_GO);
        add(OP_BEQ, 1'b0, 1'b0, E_DECODE);
        add(OP_BEQ, 1'b0, 1'b1, E_BR_NT);
        // jal
        add(OP_JAL, 1'b0, 1'b1, E_FETCH_GO);
        add(OP_JAL, 1'b0, 1'b0, E_DECODE);
        add(OP_JAL, 1'b0, 1'b0, E_JAL);
        add(OP_JAL, 1'b0, 1'b0, E_ALU_WB);
        // sw with one wait state.
        add(OP_SW,  1'b0, 1'b1, E_FETCH_GO);
        add(OP_SW,  1'b0, 1'b1, E_DECODE);
        add(OP_SW,  1'b0, 1'b1, E_MEM_ADR);
        add(OP_SW,  1'b0, 1'b0, E_WR_WAIT);
        add(OP_SW,  1'b0, 1'b1, E_WR_GO);
        // Unsupported opcode parks in TRAP with no further requests.
        add(OP_BAD, 1'b0, 1'b1, E_FETCH_GO);
        add(OP_BAD, 1'b0, 1'b1, E_DECODE);
        add(OP_BAD, 1'b0, 1'b1, E_TRAP);
        add(OP_R,   1'b1, 1'b1, E_TRAP);
        add(OP_LW,  1'b0, 1'b1, E_TRAP);

        #2;
        check_now(E_ZERO, "reset_state");

        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        check_now(E_ZERO, "start_after_release");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Only reset leaves TRAP.
        #2;
        rst_n = 1'b0;
        check_now(E_ZERO, "trap_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        check_now(E_ZERO, "trap_restart_start");

        // Reset asserted while a store waits in MEM_WR.
        step(OP_SW, 1'b0, 1'b1, E_FETCH_GO, "sw_fetch");
        step(OP_SW, 1'b0, 1'b1, E_DECODE,   "sw_decode");
        step(OP_SW, 1'b0, 1'b1, E_MEM_ADR,  "sw_mem_adr");
        step(OP_SW, 1'b0, 1'b0, E_WR_WAIT,  "sw_wr_wait");
        #2;
        rst_n = 1'b0;
        check_now(E_ZERO, "sw_reset_async");
        mem_ready = 1'b1;
        step(OP_SW, 1'b0, 1'b1, E_ZERO, "sw_reset_held");
        rst_n = 1'b1;
        check_now(E_ZERO, "sw_restart_start");
        step(OP_R, 1'b0, 1'b1, E_FETCH_GO, "post_fetch");
        step(OP_R, 1'b0, 1'b1, E_DECODE,   "post_decode");
        step(OP_R, 1'b0, 1'b1, E_EXEC_R,   "post_exec_r");
        step(OP_R, 1'b0, 1'b1, E_ALU_WB,   "post_alu_wb");

        // R, I, lw, beq x2, jal, sw in the table plus the final R-type.
        n_cmp++;
        if (n_retire != 8) begin
            n_fail++;
            $display("FAIL retire_count: got %0d required %0d", n_retire, 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
